// File: rtl/note_quant.sv
// rtl/note_quant.sv - peak frequency to MIDI note quantizer with stability filter
module note_quant #(
  parameter int BIT_WIDTH  = 16,
  parameter int NOTE_LO    = 40,
  parameter int NOTE_HI    = 88,
  parameter int STABLE_CNT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH:0]   frequency,
  input  logic                 note_dec,
  output logic [6:0]           note_idx,
  output logic                 in_range,
  output logic                 note_valid,
  output logic                 note_stable,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  // Upper edge of note m: 440 Hz scaled to the half-semitone above m, rounded.
  function automatic logic [BIT_WIDTH:0] u_of(input int m);
    real r;
    r = 440.0 * (2.0 ** ((real'(m) - 68.5) / 12.0));
    return (BIT_WIDTH+1)'($rtoi(r + 0.5));
  endfunction

  logic [BIT_WIDTH:0] ubound [NOTE_LO-1:NOTE_HI];

  for (genvar g = NOTE_LO - 1; g <= NOTE_HI; g++) begin : g_tab
    localparam logic [BIT_WIDTH:0] UVAL = u_of(g);
    assign ubound[g] = UVAL;
  end

  state_t             state_q;
  logic [BIT_WIDTH:0] f_q;
  logic [6:0]         m_q;
  logic [3:0]         scnt_q;
  logic [3:0]         scnt_d;
  logic [6:0]         note_idx_q;
  logic               in_range_q;
  logic               note_valid_q;
  logic               note_stable_q;
  logic               busy_q;

  logic below, hit, last, res_done, res_in;

  always_comb begin
    below    = (m_q == 7'(NOTE_LO)) && (f_q < ubound[NOTE_LO-1]);
    hit      = f_q < ubound[m_q];
    last     = m_q == 7'(NOTE_HI);
    res_done = below || hit || last;
    res_in   = !below && hit;
    scnt_d   = 4'd0;
    if (res_in) begin
      if (in_range_q && (m_q == note_idx_q)) begin
        scnt_d = (scnt_q >= 4'(STABLE_CNT)) ? 4'(STABLE_CNT) : scnt_q + 4'd1;
      end else begin
        scnt_d = 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      f_q           <= '0;
      m_q           <= '0;
      scnt_q        <= '0;
      note_idx_q    <= '0;
      in_range_q    <= 1'b0;
      note_valid_q  <= 1'b0;
      note_stable_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (note_dec) begin
            f_q     <= frequency;
            m_q     <= 7'(NOTE_LO);
            busy_q  <= 1'b1;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          if (res_done) begin
            note_idx_q    <= res_in ? m_q : 7'd0;
            in_range_q    <= res_in;
            scnt_q        <= scnt_d;
            note_stable_q <= scnt_d >= 4'(STABLE_CNT);
            note_valid_q  <= 1'b1;
            state_q       <= DONE;
          end else begin
            m_q <= m_q + 7'd1;
          end
        end
        DONE: begin
          note_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign note_idx    = note_idx_q;
  assign in_range    = in_range_q;
  assign note_valid  = note_valid_q;
  assign note_stable = note_stable_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_note_quant.sv
// tb/tb_note_quant.sv - scoreboard bench for note_quant
module tb_note_quant;

  localparam int LO = 40;
  localparam int HI = 88;
  localparam int SC = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [16:0] frequency = '0;
  logic        note_dec = 1'b0;
  logic [6:0]  note_idx;
  logic        in_range, note_valid, note_stable, busy;

  note_quant dut (
    .clk(clk), .reset(reset), .frequency(frequency), .note_dec(note_dec),
    .note_idx(note_idx), .in_range(in_range), .note_valid(note_valid),
    .note_stable(note_stable), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int k; int lat; int idx; bit inr; bit stb;} exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;
  int m_prev = 0;
  bit m_inr = 0;
  int m_scnt = 0;
  int free_c = 0;

  function automatic void chk(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic int ub(int m);
    real r;
    r = 440.0 * (2.0 ** ((real'(m) - 68.5) / 12.0));
    return $rtoi(r + 0.5);
  endfunction

  function automatic void quantize(input int f, output int idx, output bit inr, output int lat);
    bit found;
    idx = 0; inr = 0; lat = 2 + HI - LO; found = 0;
    if (f < ub(LO - 1)) begin
      lat = 2; found = 1;
    end
    for (int m = LO; m <= HI; m++) begin
      if (!found && f < ub(m)) begin
        idx = m; inr = 1; lat = 2 + m - LO; found = 1;
      end
    end
  endfunction

  task automatic send(input int f);
    exp_t e;
    int idx, lat;
    bit inr;
    note_dec = 1'b1;
    frequency = 17'(f);
    if (cyc >= free_c) begin
      quantize(f, idx, inr, lat);
      if (!inr) m_scnt = 0;
      else if (m_inr && idx == m_prev) m_scnt = (m_scnt + 1 > SC) ? SC : m_scnt + 1;
      else m_scnt = 1;
      m_prev = idx; m_inr = inr;
      e.k = cyc; e.lat = lat; e.idx = idx; e.inr = inr; e.stb = (m_scnt >= SC);
      q.push_back(e);
      free_c = cyc + lat + 1;
    end
    @(negedge clk);
    note_dec = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && note_valid) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid actual=note %0d required=no pulse (cycle %0d)", note_idx, cyc);
      end else begin
        e = q.pop_front();
        chk("latency", cyc - e.k, e.lat);
        chk("note_idx", int'(note_idx), e.idx);
        chk("in_range", int'(in_range), int'(e.inr));
        chk("note_stable", int'(note_stable), int'(e.stb));
        chk("busy_in_done", int'(busy), 1);
      end
    end
  end

  int dir_f[] = '{440, 93, 90, 89, 80, 79, 0, 1356, 1357,
                  440, 440, 440, 466, 0, 440, 440, 440};

  initial begin
    int t, f, r;
    gap(3);
    chk("rst_note_idx", int'(note_idx), 0);
    chk("rst_in_range", int'(in_range), 0);
    chk("rst_note_valid", int'(note_valid), 0);
    chk("rst_note_stable", int'(note_stable), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b1;
    free_c = cyc;
    gap(2);

    foreach (dir_f[i]) begin
      send(dir_f[i]);
      gap(60);
    end

    // second strobe lands five cycles after the first and must be dropped
    send(440);
    gap(4);
    send(1000);
    gap(60);

    // reset in the middle of a search kills the pending result
    send(1000);
    gap(10);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_note_idx", int'(note_idx), 0);
    chk("midrst_in_range", int'(in_range), 0);
    chk("midrst_note_valid", int'(note_valid), 0);
    chk("midrst_note_stable", int'(note_stable), 0);
    reset = 1'b1;
    q.delete();
    m_prev = 0; m_inr = 0; m_scnt = 0;
    free_c = cyc;
    @(negedge clk);
    chk("postrst_busy", int'(busy), 0);
    chk("postrst_note_valid", int'(note_valid), 0);
    send(440);
    gap(60);

    f = 440;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: f = $urandom_range(0, 100);
        1: f = $urandom_range(1300, 1400);
        2: ;
        3: f = $urandom_range(0, 131071);
        default: f = $urandom_range(80, 1400);
      endcase
      send(f);
      gap($urandom_range(0, 60));
    end

    t = 0;
    while (q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    gap(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
